aria_round_l1: RTL



---
 rtl/aria_round_l1_if.sv | 23 ++
 rtl/aria_round_l1.sv | 130 +++++++++++++
 2 files changed

// File: rtl/aria_round_l1_if.sv
// Handshake and data bundle for the ARIA substitution layer.
// The block is start/done based: a start pulse is accepted only while idle, and l1_done pulses once when l1 is complete.
interface aria_round_l1_if;
  logic         l1_start;
  logic [127:0] l1_din;
  logic [127:0] l1_rk;
  logic         l1_opt_even;
  logic         l1_clr;
  logic [127:0] l1;
  logic         l1_busy;
  logic         l1_done;
  logic [1:0]   dbg_state;

  modport master (
    output l1_start, l1_din, l1_rk, l1_opt_even, l1_clr,
    input  l1, l1_busy, l1_done, dbg_state
  );

  modport slave (
    input  l1_start, l1_din, l1_rk, l1_opt_even, l1_clr,
    output l1, l1_busy, l1_done, dbg_state
  );
endinterface

// File: rtl/aria_round_l1.sv
// ARIA substitution layer (SL1/SL2): key XOR, then 4 S-box lanes applied to one 32-bit word per clock.
// S-boxes are built from the GF(2^8) inverse plus affine maps, and each lane shares one inverter between forward and inverse use.
module aria_round_l1 (
  input  logic           clk,
  input  logic           rst,
  aria_round_l1_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Affine matrices as packed columns; byte j is the image of input bit j.
  localparam logic [63:0] A_COLS    = {8'h8F, 8'hC7, 8'hE3, 8'hF1, 8'hF8, 8'h7C, 8'h3E, 8'h1F};
  localparam logic [63:0] AINV_COLS = {8'h25, 8'h92, 8'h49, 8'hA4, 8'h52, 8'h29, 8'h94, 8'h4A};
  localparam logic [63:0] B_COLS    = {8'hEE, 8'h85, 8'h5F, 8'h5B, 8'hCF, 8'h12, 8'hC5, 8'hAC};
  localparam logic [63:0] BINV_COLS = {8'hEF, 8'h42, 8'h17, 8'hC7, 8'hC9, 8'h30, 8'hC3, 8'h9F};

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic [127:0] d_q;
  logic         sl2_q;
  logic [127:0] l1_q;
  logic [31:0]  word;
  logic [31:0]  word_sub;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254, which is the multiplicative inverse with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] gf_sq_n(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = gf_mul(r, r);
    return r;
  endfunction

  function automatic logic [7:0] mat_mul(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (x[j]) r = r ^ cols[8*j +: 8];
    end
    return r;
  endfunction

  // S1 / S1inv share one inverter: inverse = inv(Ainv*x ^ 05), forward = A*inv(x) ^ 63.
  function automatic logic [7:0] lane_s1(input logic [7:0] x, input logic inv);
    logic [7:0] g;
    g = gf_inv(inv ? (mat_mul(AINV_COLS, x) ^ 8'h05) : x);
    return inv ? g : (mat_mul(A_COLS, g) ^ 8'h63);
  endfunction

  // S2 = B*x^247 ^ E2 with x^247 = inv(x)^8; the inverse is (Binv*(y ^ E2))^223 = inv(.)^32.
  function automatic logic [7:0] lane_s2(input logic [7:0] x, input logic inv);
    logic [7:0] g;
    g = gf_inv(inv ? mat_mul(BINV_COLS, x ^ 8'hE2) : x);
    return inv ? gf_sq_n(g, 5) : (mat_mul(B_COLS, gf_sq_n(g, 3)) ^ 8'hE2);
  endfunction

  // cnt=0 selects the most significant word; {~cnt, 5'b0} is its bit offset.
  assign word     = d_q[{~cnt, 5'b00000} +: 32];
  assign word_sub = {lane_s1(word[31:24], sl2_q),
                     lane_s2(word[23:16], sl2_q),
                     lane_s1(word[15:8],  ~sl2_q),
                     lane_s2(word[7:0],   ~sl2_q)};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.l1_start) state_nxt = RUN;
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      d_q   <= '0;
      sl2_q <= 1'b0;
      l1_q  <= '0;
    end else if (bus.l1_clr) begin
      state <= IDLE;
      cnt   <= 2'd0;
      l1_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.l1_start) begin
            d_q   <= bus.l1_din ^ bus.l1_rk;
            sl2_q <= bus.l1_opt_even;
            cnt   <= 2'd0;
          end
        end
        RUN: begin
          l1_q[{~cnt, 5'b00000} +: 32] <= word_sub;
          cnt                          <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.l1        = l1_q;
  assign bus.l1_busy   = (state == RUN);
  assign bus.l1_done   = (state == DONE);
  assign bus.dbg_state = state;
endmodule
